// File: rtl/core_fetch_unit_pkg.sv
// rtl/core_fetch_unit_pkg.sv - fetch stage state encodings, constants and sizing helper
package core_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_ST_IDLE = 2'd0,
    FETCH_ST_REQ  = 2'd1,
    FETCH_ST_WAIT = 2'd2,
    FETCH_ST_DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          FETCH_FIFO_DEPTH = 2;

  // Occupancy counter must hold DEPTH itself, hence the extra bit.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/core_fetch_unit_fetch_fifo.sv
// rtl/core_fetch_unit_fetch_fifo.sv - registered {pc, instr} queue; flush overrides push and pop
module core_fetch_unit_fetch_fifo
  import core_fetch_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = FETCH_FIFO_DEPTH,
  localparam int CW = count_width(DEPTH),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_pc,
  input  logic [WIDTH-1:0] push_instr,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head_pc,
  output logic [WIDTH-1:0] head_instr
);

  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // A push into a full queue is legal when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        pc_mem[wr_ptr]    <= push_pc;
        instr_mem[wr_ptr] <= push_instr;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign full       = (cnt == CW'(DEPTH));
  assign empty      = (cnt == '0);
  assign count      = cnt;
  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/core_fetch_unit.sv
// rtl/core_fetch_unit.sv - PC owner, single-outstanding imem fetch FSM and decode-side queue
module core_fetch_unit
  import core_fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_4_o
);

  localparam int CW = count_width(FIFO_DEPTH);

  fetch_state_e          state_q;
  logic [DATA_WIDTH-1:0] fetch_pc_q;
  logic [DATA_WIDTH-1:0] req_pc_q;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_flush;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         count_after_pop;
  logic                  room_after_wait;
  logic [DATA_WIDTH-1:0] head_pc;
  logic [DATA_WIDTH-1:0] head_instr;

  assign redirect_target = redirect_pc_i & ~DATA_WIDTH'(3);
  assign fifo_pop        = instr_valid_o & instr_ready_i;
  assign fifo_push       = (state_q == FETCH_ST_WAIT) & imem_rvalid_i;
  assign fifo_flush      = rst_i | redirect_i;
  assign count_after_pop = fifo_count - CW'(fifo_pop);
  assign room_after_wait = (count_after_pop + CW'(1)) < CW'(FIFO_DEPTH);

  core_fetch_unit_fetch_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk_i),
    .flush      (fifo_flush),
    .push       (fifo_push),
    .push_pc    (req_pc_q),
    .push_instr (imem_rdata_i),
    .pop        (fifo_pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      // A response still owed by memory must be swallowed after reset.
      if ((state_q == FETCH_ST_WAIT || state_q == FETCH_ST_DROP) && !imem_rvalid_i)
        state_q <= FETCH_ST_DROP;
      else
        state_q <= FETCH_ST_REQ;
    end else if (redirect_i) begin
      fetch_pc_q <= redirect_target;
      case (state_q)
        FETCH_ST_REQ:  state_q <= imem_gnt_i ? FETCH_ST_DROP : FETCH_ST_REQ;
        FETCH_ST_WAIT,
        FETCH_ST_DROP: state_q <= imem_rvalid_i ? FETCH_ST_REQ : FETCH_ST_DROP;
        default:       state_q <= FETCH_ST_REQ;
      endcase
    end else begin
      case (state_q)
        FETCH_ST_IDLE: begin
          if (!fifo_full || fifo_pop) state_q <= FETCH_ST_REQ;
        end
        FETCH_ST_REQ: begin
          if (imem_gnt_i) begin
            state_q    <= FETCH_ST_WAIT;
            req_pc_q   <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + DATA_WIDTH'(4);
          end
        end
        FETCH_ST_WAIT: begin
          if (imem_rvalid_i) state_q <= room_after_wait ? FETCH_ST_REQ : FETCH_ST_IDLE;
        end
        FETCH_ST_DROP: begin
          if (imem_rvalid_i) state_q <= FETCH_ST_REQ;
        end
        default: state_q <= FETCH_ST_REQ;
      endcase
    end
  end

  assign imem_req_o    = (state_q == FETCH_ST_REQ) & ~rst_i;
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = ~fifo_empty;
  assign instr_o       = fifo_empty ? DATA_WIDTH'(NOP_INSTR) : head_instr;
  assign pc_o          = fifo_empty ? '0 : head_pc;
  assign pc_4_o        = pc_o + DATA_WIDTH'(4);

endmodule

// File: tb/tb_core_fetch_unit.sv
// tb/tb_core_fetch_unit.sv - directed scoreboard bench for core_fetch_unit
module tb_core_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_4_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  logic        gnt_en = 1'b1;
  int          lat = 1;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  core_fetch_unit dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_4_o        (pc_4_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: gnt follows gnt_en; rvalid arrives lat cycles after a grant.
  always begin
    @(negedge clk);
    #1;
    imem_gnt_i    = gnt_en;
    imem_rvalid_i = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(pend_addr);
        pend          = 1'b0;
      end
    end
    if (imem_req_o && gnt_en) begin
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_addr = imem_addr_o;
    end
  end

  // Monitor: every accepted instruction must match the scoreboard head.
  always begin
    logic [31:0] e;
    logic [31:0] e4;
    @(negedge clk);
    #2;
    if (instr_valid_o && instr_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got pc %h expected no instruction", pc_o);
      end else begin
        checks--;
        e  = exp_q.pop_front();
        e4 = e + 32'd4;
        chk("mon_pc", pc_o, e);
        chk("mon_pc_4", pc_4_o, e4);
        chk("mon_instr", instr_o, mem_word(e));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    redirect_i = 1'b0;
    #3;
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    @(negedge clk);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    #3;
  endtask

  task automatic wait_req(input string name, input logic [31:0] addr, input logic check_addr);
    for (int n = 0; n < 40; n++) begin
      step();
      if (imem_req_o) begin
        if (check_addr) chk(name, imem_addr_o, addr);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: got no request expected request", name);
  endtask

  task automatic accept_one(input string name);
    @(negedge clk);
    redirect_i    = 1'b0;
    instr_ready_i = 1'b1;
    #3;
    for (int n = 0; n < 40; n++) begin
      if (instr_valid_o) begin
        @(negedge clk);
        instr_ready_i = 1'b0;
        #3;
        return;
      end
      step();
    end
    instr_ready_i = 1'b0;
    checks++;
    errors++;
    $display("FAIL %s_timeout: got no valid instruction expected one", name);
  endtask

  initial begin
    int n_req;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'h0000_0013);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_pc_4", pc_4_o, 32'h4);

    // Sequential fetch at a 2-cycle cadence
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    @(negedge clk);
    rst_i = 1'b0;
    instr_ready_i = 1'b1;
    #3;
    chk("seq_req0", {31'd0, imem_req_o}, 32'd1);
    chk("seq_addr0", imem_addr_o, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("seq_req", {31'd0, imem_req_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) chk("seq_addr", imem_addr_o, 32'(4 * (i / 2)));
    end

    // Backpressure: two entries buffered, then no more requests
    @(negedge clk);
    instr_ready_i = 1'b0;
    #3;
    chk("bp_req_c7", {31'd0, imem_req_o}, 32'd0);
    step();
    chk("bp_req_c8", {31'd0, imem_req_o}, 32'd1);
    chk("bp_addr_c8", imem_addr_o, 32'h10);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_req_idle", {31'd0, imem_req_o}, 32'd0);
      chk("bp_valid", {31'd0, instr_valid_o}, 32'd1);
      chk("bp_head_pc", pc_o, 32'hC);
    end

    // One pop releases exactly one request
    exp_q.push_back(32'hC);
    @(negedge clk);
    instr_ready_i = 1'b1;
    #3;
    @(negedge clk);
    instr_ready_i = 1'b0;
    #3;
    n_req = int'(imem_req_o);
    chk("refill_addr", imem_addr_o, 32'h14);
    for (int i = 0; i < 5; i++) begin
      step();
      n_req += int'(imem_req_o);
    end
    chk("refill_count", 32'(n_req), 32'd1);
    chk("refill_head", pc_o, 32'h10);

    // Redirect while a response is pending
    lat = 3;
    pulse_redirect(32'h200);
    wait_req("rw_first", 32'h200, 1'b1);
    pulse_redirect(32'h103);
    step();
    chk("rw_drop_req", {31'd0, imem_req_o}, 32'd0);
    chk("rw_valid", {31'd0, instr_valid_o}, 32'd0);
    exp_q.push_back(32'h100);
    wait_req("rw_addr", 32'h100, 1'b1);
    accept_one("rw_accept");

    // Redirect in the same cycle as a grant
    lat = 1;
    wait_req("rg_any", 32'h0, 1'b0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h300;
    step();
    chk("rg_drop_req", {31'd0, imem_req_o}, 32'd0);
    exp_q.push_back(32'h300);
    wait_req("rg_addr", 32'h300, 1'b1);
    accept_one("rg_accept");

    // Redirect in the same cycle as rvalid
    wait_req("rv_any", 32'h0, 1'b0);
    pulse_redirect(32'h400);
    exp_q.push_back(32'h400);
    @(negedge clk);
    redirect_i    = 1'b0;
    instr_ready_i = 1'b1;
    #3;
    chk("rv_req", {31'd0, imem_req_o}, 32'd1);
    chk("rv_addr", imem_addr_o, 32'h400);
    accept_one("rv_accept");

    // Grant stalls hold the request; redirect may still move it
    gnt_en = 1'b0;
    pulse_redirect(32'h500);
    wait_req("gs_first", 32'h500, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("gs_req_hold", {31'd0, imem_req_o}, 32'd1);
      chk("gs_addr_hold", imem_addr_o, 32'h500);
    end
    pulse_redirect(32'h600);
    step();
    chk("gs_req_new", {31'd0, imem_req_o}, 32'd1);
    chk("gs_addr_new", imem_addr_o, 32'h600);
    exp_q.push_back(32'h600);
    @(negedge clk);
    gnt_en = 1'b1;
    #3;
    accept_one("gs_accept");

    // PC wrap
    pulse_redirect(32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    wait_req("wrap_first", 32'hFFFF_FFFC, 1'b1);
    wait_req("wrap_next", 32'h0, 1'b1);
    accept_one("wrap_acc0");
    accept_one("wrap_acc1");

    // Reset while a response is outstanding
    lat = 3;
    pulse_redirect(32'h700);
    wait_req("mr_first", 32'h700, 1'b1);
    @(negedge clk);
    rst_i = 1'b1;
    #3;
    chk("mr_req_in_rst", {31'd0, imem_req_o}, 32'd0);
    chk("mr_valid_in_rst", {31'd0, instr_valid_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    #3;
    chk("mr_req_drop", {31'd0, imem_req_o}, 32'd0);
    exp_q.push_back(32'h0);
    wait_req("mr_addr", 32'h0, 1'b1);
    accept_one("mr_accept");

    step();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/core_fetch_unit.md
# core_fetch_unit

Instruction fetch stage that owns the program counter and consumes the branch unit's redirect output. Issues word fetches to instruction memory over a req/gnt/rvalid handshake and keeps at most one request outstanding. Buffers returned instructions with their PC in a 2-entry queue and presents them to decode over a valid/ready handshake. Also supplies `pc_4_o`, the link value consumed by JAL/JALR write-back.

## Interface
- `DATA_WIDTH`, 32, instruction, PC and address width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `FIFO_DEPTH`, 2, instruction queue entries; legal values are 2 and 4.

Ports:
- `clk_i` in 1: the single clock; all state updates on its rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `redirect_i` in 1: a taken branch or jump is to be applied this cycle.
- `redirect_pc_i` in DATA_WIDTH: target PC; bits [1:0] are forced to 0 internally.
- `imem_req_o` out 1: fetch request valid.
- `imem_addr_o` out DATA_WIDTH: fetch address; always word-aligned.
- `imem_gnt_i` in 1: memory accepts the request this cycle.
- `imem_rvalid_i` in 1: response data valid.
- `imem_rdata_i` in DATA_WIDTH: instruction word.
- `instr_valid_o` out 1: queue head valid.
- `instr_ready_i` in 1: decode accepts the head.
- `instr_o` out DATA_WIDTH: head instruction.
- `pc_o` out DATA_WIDTH: PC of the head instruction.
- `pc_4_o` out DATA_WIDTH: `pc_o + 4`, modulo 2^DATA_WIDTH.

## Operation
- **State machine:** `IDLE`, `REQ`, `WAIT`, `DROP`. Held in a registered state variable; `imem_req_o = (state == REQ)`.
- **IDLE:**
  - Go to `REQ` when `count + 0 < FIFO_DEPTH`.
  - `count` is the number of queue entries after this cycle's pop.
- **REQ:**
  - `imem_addr_o = fetch_pc`.
  - On `imem_gnt_i`, go to `WAIT` and set `fetch_pc += 4`. The in-flight PC is saved as `req_pc`.
- **WAIT:**
  - On `imem_rvalid_i`, push `{req_pc, imem_rdata_i}` into the queue.
  - Then go to `REQ` if the queue still has room after the push and pop, otherwise to `IDLE`.
- **DROP:**
  - On `imem_rvalid_i`, discard the data and go to `REQ`.
- **Redirect:** `redirect_i` has priority over everything else in that cycle.
  - The queue is cleared, including any same-cycle push or pop.
  - `fetch_pc` is set to `{redirect_pc_i[31:2], 2'b00}`.
  - From `IDLE` or `REQ` without gnt: go to `REQ`. The address changes without a grant; the memory tolerates this on redirect only.
  - From `REQ` with gnt: the granted request is stale, so go to `DROP`.
  - From `WAIT` without rvalid: go to `DROP`.
  - From `WAIT` with rvalid: the data is dropped; go to `REQ`.
  - From `DROP` with rvalid: go to `REQ`. Without rvalid: stay in `DROP`.
- **Request hold:** the address stays stable while `imem_req_o` is high without gnt, except on redirect.
- **Queue full:** no request is issued. `imem_rvalid_i` never arrives when the queue is full, because a request is issued only with room reserved.
- **Simultaneous push and pop on a full queue:** allowed.
- **Empty queue outputs:** `instr_valid_o = 0`, `instr_o = 32'h0000_0013` (NOP), `pc_o = 0`, `pc_4_o = 4`.
- **PC wrap:** wraps modulo 2^DATA_WIDTH with no error.

## Timing
- **Reset values (cycle with `rst_i` high and the cycle after):**
  - state = `REQ`, `fetch_pc = RESET_PC`.
  - `imem_req_o` = 0 while `rst_i` is high, then 1 with `imem_addr_o = RESET_PC` in the first cycle after reset.
  - Queue empty, so `instr_valid_o` = 0 and `instr_o` = NOP.
- **Mid-operation reset:** an outstanding response arriving after reset is ignored. Reset puts the block in `DROP` when a grant was outstanding, otherwise in `REQ`.
- **Memory protocol:** gnt is in the same cycle as req. rvalid comes at least 1 cycle after gnt.
- **Latency:** rvalid in cycle t gives `instr_valid_o` in t+1. The queue is registered with no bypass.
- **Throughput:** with 1-cycle memory, one instruction every 2 cycles.
- **Redirect:** `redirect_i` at edge N gives `imem_req_o` with the new address in cycle N+1, or after the discarded response if the block is in `DROP`. `instr_valid_o` is 0 from N+1 until the new data returns.
- **Decode handshake:** a pop occurs when `instr_valid_o & instr_ready_i`. The head is stable while valid and not ready.

## Structure
- **Shared `defines.vh`:**
  - `FETCH_ST_*` state encodings, 2 bits.
  - `NOP_INSTR` = 32'h0000_0013.
  - `RESET_PC` default.
  - `FETCH_FIFO_DEPTH`.
- **Sub-module `fetch_fifo`:** synchronous FIFO of `{pc, instr}`.
  - Ports: push, pop, flush, full, empty, count.
  - Flush overrides push and pop.
- **Top:** FSM, `fetch_pc`/`req_pc` registers, `pc_4_o` adder.

## Test plan
- **Reset and sequential fetch:** release reset with gnt always 1 and rvalid 1 cycle later → addresses 0x0, 0x4, 0x8 at a 2-cycle cadence. `pc_o` 0x0/0x4/0x8 and `pc_4_o` 0x4/0x8/0xC.
- **Backpressure:** `instr_ready_i` = 0 → two entries buffered, then `imem_req_o` stays 0. One pop → exactly one new request. No entries lost or duplicated.
- **Redirect in WAIT:** `redirect_pc_i` = 0x103 while a response is pending → the response is discarded (`DROP`). Next request address is 0x100, and the next valid instruction has `pc_o` = 0x100.
- **Redirect with same-cycle gnt, and redirect with same-cycle rvalid:** neither the stale instruction nor the stale PC ever appears on `instr_o`/`pc_o`.
- **Gnt stalls:** `imem_gnt_i` low for 5 cycles → `imem_addr_o` held constant, `imem_req_o` held high.
- **Wrap and reset mid-flight:**
  - `redirect_pc_i` = 0xFFFF_FFFC → next fetch address is 0x0, `pc_4_o` = 0x0.
  - `rst_i` pulse while `WAIT` → the late rvalid is ignored, and the first valid instruction has `pc_o = RESET_PC`.
